// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter for the I-cache and D-cache controllers: block fills,
// D-side write-throughs, response routing and one-transaction fairness for the I side.
module mem_arbiter #(
   parameter int unsigned WORDS       = 8,
   parameter int unsigned MEM_LATENCY = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     icache_req,
   input  logic [15:0]              icache_addr,
   output logic                     icache_grant,
   output logic [15:0]              icache_data,
   output logic                     icache_data_valid,
   output logic [$clog2(WORDS)-1:0] icache_word,
   output logic                     icache_done,
   input  logic                     dcache_req,
   input  logic                     dcache_write,
   input  logic [15:0]              dcache_addr,
   input  logic [15:0]              dcache_wdata,
   output logic                     dcache_grant,
   output logic [15:0]              dcache_data,
   output logic                     dcache_data_valid,
   output logic [$clog2(WORDS)-1:0] dcache_word,
   output logic                     dcache_done,
   output logic                     mem_en,
   output logic                     mem_wr,
   output logic [15:0]              mem_addr,
   output logic [15:0]              mem_wdata,
   input  logic [15:0]              mem_rdata,
   input  logic                     mem_valid
);

   localparam int unsigned CW        = $clog2(WORDS);
   localparam logic [CW:0] ISSUE_N   = (CW+1)'(WORDS);
   localparam logic [CW-1:0] LAST_W  = CW'(WORDS - 1);
   localparam logic [15:0] BLK_MASK  = ~16'(2 * WORDS - 1);

   typedef enum logic [1:0] {IDLE, IFILL, DFILL, DWRITE} state_t;

   state_t        state;
   logic [CW:0]   issue_cnt;
   logic [CW-1:0] recv_cnt;
   logic [15:0]   base;
   logic          fair;
   logic          fill;
   logic          rx;
   logic          last_rx;

   always_comb begin
      fill              = (state == IFILL) || (state == DFILL);
      rx                = fill && mem_valid;
      last_rx           = rx && (recv_cnt == LAST_W);
      icache_data_valid = rx && (state == IFILL);
      icache_data       = icache_data_valid ? mem_rdata : '0;
      icache_word       = icache_data_valid ? recv_cnt : '0;
      icache_done       = last_rx && (state == IFILL);
      dcache_data_valid = rx && (state == DFILL);
      dcache_data       = dcache_data_valid ? mem_rdata : '0;
      dcache_word       = dcache_data_valid ? recv_cnt : '0;
      dcache_done       = (last_rx && (state == DFILL)) || (state == DWRITE);
   end

   // Memory strobes are registered: the entry edge already presents the first access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         issue_cnt    <= '0;
         recv_cnt     <= '0;
         base         <= '0;
         fair         <= 1'b0;
         icache_grant <= 1'b0;
         dcache_grant <= 1'b0;
         mem_en       <= 1'b0;
         mem_wr       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         case (state)
            IDLE: begin
               if (dcache_req && (!icache_req || !fair)) begin
                  dcache_grant <= 1'b1;
                  mem_en       <= 1'b1;
                  if (dcache_write) begin
                     state     <= DWRITE;
                     mem_wr    <= 1'b1;
                     mem_addr  <= dcache_addr;
                     mem_wdata <= dcache_wdata;
                  end else begin
                     state     <= DFILL;
                     base      <= dcache_addr & BLK_MASK;
                     mem_addr  <= dcache_addr & BLK_MASK;
                     issue_cnt <= (CW+1)'(1);
                  end
               end else if (icache_req) begin
                  state        <= IFILL;
                  icache_grant <= 1'b1;
                  fair         <= 1'b0;
                  base         <= icache_addr & BLK_MASK;
                  mem_en       <= 1'b1;
                  mem_addr     <= icache_addr & BLK_MASK;
                  issue_cnt    <= (CW+1)'(1);
               end
            end
            IFILL, DFILL: begin
               if (issue_cnt < ISSUE_N) begin
                  mem_en    <= 1'b1;
                  mem_addr  <= base + (16'(issue_cnt) << 1);
                  issue_cnt <= issue_cnt + 1'b1;
               end
               if (rx) recv_cnt <= recv_cnt + 1'b1;
               if (last_rx) begin
                  state        <= IDLE;
                  icache_grant <= 1'b0;
                  dcache_grant <= 1'b0;
                  issue_cnt    <= '0;
                  recv_cnt     <= '0;
                  if (state == DFILL && icache_req) fair <= 1'b1;
               end
            end
            DWRITE: begin
               state        <= IDLE;
               dcache_grant <= 1'b0;
               if (icache_req) fair <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_first_word_latency : assert property (@(posedge clk) disable iff (!rst)
      (rx && recv_cnt == '0) |-> $past(mem_en, MEM_LATENCY));
   a_single_grant : assert property (@(posedge clk) disable iff (!rst)
      !(icache_grant && dcache_grant));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed-latency memory, two request agents, and a
// transaction-level reference that predicts every output from cycle offsets.
module tb_mem_arbiter;

   localparam int W   = 8;
   localparam int LAT = 4;
   localparam logic [15:0] MASK = 16'hFFF0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        icache_req = 1'b0;
   logic [15:0] icache_addr = '0;
   logic        icache_grant, icache_data_valid, icache_done;
   logic [15:0] icache_data;
   logic [2:0]  icache_word;
   logic        dcache_req = 1'b0;
   logic        dcache_write = 1'b0;
   logic [15:0] dcache_addr = '0;
   logic [15:0] dcache_wdata = '0;
   logic        dcache_grant, dcache_data_valid, dcache_done;
   logic [15:0] dcache_data;
   logic [2:0]  dcache_word;
   logic        mem_en, mem_wr, mem_valid;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic [77:0] outs;

   always #5 clk = ~clk;

   mem_arbiter #(.WORDS(W), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .icache_req(icache_req), .icache_addr(icache_addr), .icache_grant(icache_grant),
      .icache_data(icache_data), .icache_data_valid(icache_data_valid),
      .icache_word(icache_word), .icache_done(icache_done),
      .dcache_req(dcache_req), .dcache_write(dcache_write), .dcache_addr(dcache_addr),
      .dcache_wdata(dcache_wdata), .dcache_grant(dcache_grant), .dcache_data(dcache_data),
      .dcache_data_valid(dcache_data_valid), .dcache_word(dcache_word),
      .dcache_done(dcache_done),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid)
   );

   assign outs = {icache_grant, icache_data, icache_data_valid, icache_word, icache_done,
                  dcache_grant, dcache_data, dcache_data_valid, dcache_word, dcache_done,
                  mem_en, mem_wr, mem_addr, mem_wdata};

   function automatic logic [15:0] word_of(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h3C5A;
   endfunction

   // Pipelined memory: a read strobed in cycle c returns in cycle c+LAT; it is not reset.
   logic [LAT-1:0] pv = '0;
   logic [15:0]    pa [LAT];
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], mem_en & ~mem_wr};
      pa[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
   end
   assign mem_valid = pv[LAT-1];
   assign mem_rdata = pv[LAT-1] ? word_of(pa[LAT-1]) : 16'h5A5A;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: kind 0 none, 1 I fill, 2 D fill, 3 D write; k = cycles since entry.
   int          kind = 0;
   int          k = 0;
   bit          fair = 1'b0;
   logic [15:0] m_base = '0, m_waddr = '0, m_wdata = '0;

   bit          i_pend = 0, d_pend = 0, i_drop = 0, d_drop = 0, rnd = 0, d_repeat = 0;
   bit          nx_i = 0, nx_d = 0, nx_idrop = 0, nx_ddrop = 0, nx_dwr = 0;
   logic [15:0] nx_iaddr = '0, nx_daddr = '0, nx_dwd = '0;

   int          sc = 0, i_dv_n = 0, d_dv_n = 0, m_en_n = 0, i_done_at = -1, d_done_at = -1;
   int          i_wait = 0, max_wait = 0;
   logic [2:0]  i_first_word = '0;

   task automatic req_i(input logic [15:0] a, input bit drop);
      nx_i = 1; nx_iaddr = a; nx_idrop = drop;
   endtask

   task automatic req_d(input logic [15:0] a, input bit wr, input logic [15:0] wd, input bit drop);
      nx_d = 1; nx_daddr = a; nx_dwr = wr; nx_dwd = wd; nx_ddrop = drop;
   endtask

   task automatic begin_scn();
      sc = -1; i_dv_n = 0; d_dv_n = 0; m_en_n = 0; i_done_at = -1; d_done_at = -1;
   endtask

   task automatic step();
      bit          fl, iss, dat, e_en, e_idone, e_ddone;
      int          j;
      logic [15:0] e_addr, e_data;
      logic [2:0]  e_word;
      @(negedge clk);
      sc++;
      fl      = (kind == 1 || kind == 2);
      iss     = fl && k >= 1 && k <= W;
      dat     = fl && k > LAT && k <= W + LAT;
      j       = k - LAT - 1;
      e_word  = dat ? 3'(j) : 3'd0;
      e_data  = dat ? word_of(m_base + 16'(2 * j)) : 16'h0;
      e_en    = iss || kind == 3;
      e_addr  = (kind == 3) ? m_waddr : m_base + 16'(2 * (k - 1));
      e_idone = (kind == 1 && k == W + LAT);
      e_ddone = (kind == 2 && k == W + LAT) || kind == 3;

      check("grant", {icache_grant, dcache_grant}, {kind == 1, kind == 2 || kind == 3});
      check("mem_ctl", {mem_en, mem_wr, mem_wdata}, {e_en, kind == 3, (kind == 3) ? m_wdata : 16'h0});
      if (e_en) check("mem_addr", mem_addr, e_addr);
      check("i_port", {icache_data_valid, icache_word, icache_data, icache_done},
            {dat && kind == 1, (kind == 1) ? e_word : 3'd0, (kind == 1) ? e_data : 16'h0, e_idone});
      check("d_port", {dcache_data_valid, dcache_word, dcache_data, dcache_done},
            {dat && kind == 2, (kind == 2) ? e_word : 3'd0, (kind == 2) ? e_data : 16'h0, e_ddone});

      if (icache_data_valid) begin
         if (i_dv_n == 0) i_first_word = icache_word;
         i_dv_n++;
      end
      if (dcache_data_valid) d_dv_n++;
      if (icache_done && i_done_at < 0) i_done_at = sc;
      if (dcache_done && d_done_at < 0) d_done_at = sc;
      if (mem_en) m_en_n++;
      if (icache_grant || !icache_req) i_wait = 0;
      else if (dcache_done) i_wait++;
      if (i_wait > max_wait) max_wait = i_wait;

      // Agents: release on completion, optional early drop, new requests.
      if (e_idone) begin i_pend = 0; icache_req = 0; end
      if (e_ddone) begin
         d_pend = 0; dcache_req = 0;
         if (d_repeat) req_d(dcache_addr + 16'd2, 1, ~dcache_wdata, 0);
      end
      if (kind == 1 && k == 2 && i_drop) icache_req = 0;
      if (kind == 2 && k == 2 && d_drop) dcache_req = 0;
      if (rnd && !i_pend && !nx_i && $urandom_range(0, 3) == 0)
         req_i(16'($urandom), $urandom_range(0, 3) == 0);
      if (rnd && !d_pend && !nx_d && $urandom_range(0, 3) == 0)
         req_d(16'($urandom), $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 3) == 0);
      if (nx_i && !i_pend) begin
         icache_req = 1; icache_addr = nx_iaddr; i_drop = nx_idrop; i_pend = 1; nx_i = 0;
      end
      if (nx_d && !d_pend) begin
         dcache_req = 1; dcache_addr = nx_daddr; dcache_write = nx_dwr;
         dcache_wdata = nx_dwd; d_drop = nx_ddrop; d_pend = 1; nx_d = 0;
      end

      if (kind == 0) begin
         if (dcache_req && !(icache_req && fair)) begin
            kind = dcache_write ? 3 : 2; k = 1;
            m_base = dcache_addr & MASK; m_waddr = dcache_addr; m_wdata = dcache_wdata;
         end else if (icache_req) begin
            kind = 1; k = 1; fair = 0; m_base = icache_addr & MASK;
         end
      end else if (e_idone || e_ddone) begin
         if (e_ddone && icache_req) fair = 1;
         kind = 0; k = 0;
      end else begin
         k++;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic quiesce();
      int n = 0;
      while ((kind != 0 || i_pend || d_pend || nx_i || nx_d) && n < 200) begin
         step();
         n++;
      end
      check("quiesce", (kind != 0 || i_pend || d_pend), 1'b0);
   endtask

   initial begin
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", outs, '0);
      rst = 1'b1;

      // I fill alone from a mid-block address
      req_i(16'h0136, 0); begin_scn(); step();
      run(1); check("i_alone_addr_first", mem_addr, 16'h0130);
      run(7); check("i_alone_addr_last", mem_addr, 16'h013E);
      run(5);
      check("i_alone_done_cyc", i_done_at, 12);
      check("i_alone_words", {i_dv_n, d_dv_n}, {32'd8, 32'd0});
      check("i_alone_idle13", icache_grant, 1'b0);

      // single D write-through
      quiesce(); req_d(16'h2002, 1, 16'hBEEF, 0); begin_scn(); step();
      run(1);
      check("dw_bus", {mem_en, mem_wr, mem_addr, mem_wdata, dcache_done},
            {1'b1, 1'b1, 16'h2002, 16'hBEEF, 1'b1});
      run(1); check("dw_idle", {dcache_grant, mem_en}, 2'b00);

      // simultaneous fills: D first, I starts after one IDLE cycle
      quiesce(); req_d(16'h4000, 0, 16'h0, 0); req_i(16'h0010, 0); begin_scn(); step();
      run(13);
      check("sim_d_done", d_done_at, 12);
      check("sim_gap_idle", {icache_grant, dcache_grant}, 2'b00);
      run(1); check("sim_i_start", {icache_grant, mem_en, mem_addr}, {1'b1, 1'b1, 16'h0010});

      // fairness against back-to-back D writes
      quiesce(); d_repeat = 1; req_d(16'h3000, 1, 16'h1234, 0); req_i(16'h0200, 0);
      begin_scn(); step();
      run(1); check("fair_first_d", dcache_done, 1'b1);
      run(2); check("fair_i_wins", {icache_grant, dcache_grant}, 2'b10);
      d_repeat = 0;

      // reset in the middle of a fill, stale responses afterwards
      quiesce(); req_i(16'h0500, 0); begin_scn(); step(); run(5);
      @(posedge clk); #1 rst = 1'b0;
      #1 check("rst_mid_outs", outs, '0);
      kind = 0; k = 0; fair = 0; icache_req = 0; i_pend = 0;
      run(2);
      @(posedge clk); #1 rst = 1'b1;
      i_dv_n = 0; run(5);
      check("rst_stale_ignored", i_dv_n, 0);
      quiesce(); req_i(16'h0500, 0); begin_scn(); step(); run(5);
      check("rst_restart_word0", {i_dv_n > 0, i_first_word}, {1'b1, 3'd0});

      // D requester drops req early in a fill
      quiesce(); req_d(16'h6000, 0, 16'h0, 1); begin_scn(); step(); run(12);
      check("drop_done_cyc", d_done_at, 12);
      check("drop_words", {d_dv_n, m_en_n}, {32'd8, 32'd8});

      // randomized traffic against the reference
      rnd = 1;
      run(4000);
      rnd = 0;
      quiesce();
      check("fair_wait_max", max_wait <= 1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the I-cache and D-cache controllers and the single shared main memory. The memory is pipelined, accepts one word access per cycle and returns read data after a fixed latency.
- Arbitrates miss/write requests from both caches.
- Sequences 8-word block fills and routes returning words to the granted cache.
- Issues single-word D-cache write-throughs.
- Cache controllers hold their stall while their request is pending.

Parameters:
- WORDS, 8, words per cache block (16-bit words, 2-byte addressing).
- MEM_LATENCY, 4, cycles from a read issue to its mem_valid.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- icache_req  input  1  I-cache fill request; held until icache_done.
- icache_addr  input  16  miss byte address.
- icache_grant  output  1  I-cache owns memory.
- icache_data  output  16  fill word.
- icache_data_valid  output  1  icache_data/icache_word valid this cycle.
- icache_word  output  3  word index within block.
- icache_done  output  1  one-cycle pulse, transaction complete.
- dcache_req  input  1  D-cache request; held until dcache_done.
- dcache_write  input  1  1 = single-word write, 0 = block fill.
- dcache_addr  input  16  byte address.
- dcache_wdata  input  16  write data.
- dcache_grant, dcache_data, dcache_data_valid, dcache_word, dcache_done  output  1/16/1/3/1  same meaning as the I-side outputs.
- mem_en  output  1  memory access strobe.
- mem_wr  output  1  write when mem_en.
- mem_addr  output  16  memory byte address.
- mem_wdata  output  16  memory write data.
- mem_rdata  input  16  read data.
- mem_valid  input  1  mem_rdata valid.

Behaviour:
- Reset (rst=0, async): state IDLE, issue/recv counters 0, fairness flag 0, all outputs 0.
- States: IDLE, IFILL, DFILL, DWRITE.
- IDLE selection, evaluated each cycle; the new state takes effect next edge:
  - Only dcache_req set: DFILL if dcache_write=0, DWRITE if dcache_write=1.
  - Only icache_req set: IFILL.
  - Both set: D side wins unless the fairness flag is set, then I side wins.
- Fairness flag:
  - Set when icache_req is high while a D transaction completes.
  - Cleared when IFILL is entered.
  - Guarantees the I side waits at most one D transaction.
- Grant outputs are registered: high for every cycle in the matching state, low in IDLE.
- Fill (IFILL/DFILL):
  - base = addr & 16'hFFF0.
  - Issue phase: cycles 1..WORDS after entry. mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt; issue_cnt increments 0..7, then mem_en=0.
  - Each mem_valid in a fill state: forward mem_rdata to the granted cache's data, assert its data_valid, set word = recv_cnt, increment recv_cnt.
  - The cycle delivering word WORDS-1 also pulses done. Next state IDLE.
  - Nominal timing: issue cycles 1-8, data cycles 5-12, done cycle 12, IDLE cycle 13.
  - A fill runs to completion even if the requester drops req mid-fill; data is still delivered.
- DWRITE:
  - Entry cycle: mem_en=1, mem_wr=1, mem_addr=dcache_addr, mem_wdata=dcache_wdata, dcache_done=1.
  - Next state IDLE. Total occupancy 1 cycle.
- At least one IDLE cycle separates transactions; a held request is re-evaluated there.
- mem_valid in IDLE or DWRITE is ignored: no data_valid.
- mem_wr=0 and mem_wdata=0 whenever not in DWRITE.
- data/word outputs are 0 when the matching data_valid is 0.
- Reset mid-fill: immediate return to IDLE, counters cleared. Stale mem_valid responses after rst deasserts are ignored (state is IDLE). Requesters re-issue.
- Never more than one grant high; never both done pulses in one cycle.

Test Plan:
- I fill alone: icache_req=1, icache_addr=16'h0136, memory returns addr-based data:
  - mem_addr 0x0130,0x0132,…,0x013E in cycles 1-8.
  - icache_data_valid cycles 5-12, icache_word 0..7.
  - icache_done at cycle 12; dcache outputs stay 0.
- D write: dcache_req=1, dcache_write=1, addr 0x2002, wdata 0xBEEF:
  - One cycle with mem_en=1, mem_wr=1, mem_addr=0x2002, mem_wdata=0xBEEF, dcache_done=1.
  - IDLE next cycle.
- Simultaneous requests: both req=1 at cycle 0, D fill at 0x4000, I fill at 0x0010:
  - DFILL completes first (done cycle 12).
  - IFILL starts cycle 14; mem_addr 0x0010 is issued in cycle 14.
- Fairness: I req held while D issues back-to-back writes:
  - After the first D write completes, IFILL is entered even though dcache_req is still high.
- Reset mid-fill: rst=0 at cycle 6 of an IFILL, released at cycle 8 with mem_valid still pulsing:
  - All outputs 0 from the reset edge.
  - No icache_data_valid after release.
  - A new icache_req restarts at word 0.
- Requester drops req at cycle 3 of DFILL:
  - All 8 words are still issued and delivered; dcache_done pulses at cycle 12.
